// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the three memory masters, the arbiter and the single-port memory.
// The slave modport is the arbiter's view; the master modport is the masters-plus-memory side.
interface mem_bus_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic              m0_req_i;
    logic              m0_we_i;
    logic [AW-1:0]     m0_addr_i;
    logic [DW-1:0]     m0_wdata_i;
    logic [DW/8-1:0]   m0_wstrb_i;
    logic              m0_gnt_o;
    logic              m0_rvalid_o;
    logic [DW-1:0]     m0_rdata_o;
    logic              m0_lock_i;

    logic              m1_req_i;
    logic              m1_we_i;
    logic [AW-1:0]     m1_addr_i;
    logic [DW-1:0]     m1_wdata_i;
    logic [DW/8-1:0]   m1_wstrb_i;
    logic              m1_gnt_o;
    logic              m1_rvalid_o;
    logic [DW-1:0]     m1_rdata_o;

    logic              m2_req_i;
    logic              m2_we_i;
    logic [AW-1:0]     m2_addr_i;
    logic [DW-1:0]     m2_wdata_i;
    logic [DW/8-1:0]   m2_wstrb_i;
    logic              m2_gnt_o;
    logic              m2_rvalid_o;
    logic [DW-1:0]     m2_rdata_o;

    logic              hold_o;
    logic              s_en_o;
    logic              s_we_o;
    logic [AW-1:0]     s_addr_o;
    logic [DW-1:0]     s_wdata_o;
    logic [DW/8-1:0]   s_wstrb_o;
    logic [DW-1:0]     s_rdata_i;

    modport slave (
        input  m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i, m0_wstrb_i, m0_lock_i,
        input  m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i, m1_wstrb_i,
        input  m2_req_i, m2_we_i, m2_addr_i, m2_wdata_i, m2_wstrb_i,
        input  s_rdata_i,
        output m0_gnt_o, m0_rvalid_o, m0_rdata_o,
        output m1_gnt_o, m1_rvalid_o, m1_rdata_o,
        output m2_gnt_o, m2_rvalid_o, m2_rdata_o,
        output hold_o, s_en_o, s_we_o, s_addr_o, s_wdata_o, s_wstrb_o
    );

    modport master (
        output m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i, m0_wstrb_i, m0_lock_i,
        output m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i, m1_wstrb_i,
        output m2_req_i, m2_we_i, m2_addr_i, m2_wdata_i, m2_wstrb_i,
        output s_rdata_i,
        input  m0_gnt_o, m0_rvalid_o, m0_rdata_o,
        input  m1_gnt_o, m1_rvalid_o, m1_rdata_o,
        input  m2_gnt_o, m2_rvalid_o, m2_rdata_o,
        input  hold_o, s_en_o, s_we_o, s_addr_o, s_wdata_o, s_wstrb_o
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Fixed-priority arbiter (loader > load/store > fetch) for a single-port memory, with a fetch
// starvation guard and a loader lock that stalls the core while the loader owns the bus.
module mem_bus_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    mem_bus_arbiter_if.slave  bus
);
    localparam int BW = DW / 8;
    localparam int SW = $clog2(STARVE_MAX + 1);

    localparam logic [1:0] OWN_M0 = 2'd0;
    localparam logic [1:0] OWN_M1 = 2'd1;
    localparam logic [1:0] OWN_M2 = 2'd2;

    typedef enum logic [0:0] {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } lock_state_e;

    lock_state_e   state_q;
    logic [1:0]    owner_q;
    logic [1:0]    owner_d;
    logic          valid_q;
    logic          valid_d;
    logic [SW-1:0] starve_q;
    logic [SW-1:0] starve_d;

    logic [2:0]    req_s;
    logic [2:0]    gnt_s;
    logic          starved_s;
    logic          m0_pending_s;
    logic [2:0]    rvalid_s;

    logic          s_en_s;
    logic          s_we_s;
    logic [AW-1:0] s_addr_s;
    logic [DW-1:0] s_wdata_s;
    logic [BW-1:0] s_wstrb_s;

    assign req_s        = {bus.m2_req_i, bus.m1_req_i, bus.m0_req_i};
    assign starved_s    = (starve_q == SW'(STARVE_MAX));
    assign m0_pending_s = valid_q && (owner_q == OWN_M0);

    // Winner selection; the starvation guard only swaps M1/M2, the loader always wins.
    always_comb begin
        gnt_s = 3'b000;
        if (rst) begin
            gnt_s = 3'b000;
        end else if (req_s[0]) begin
            gnt_s = 3'b001;
        end else if (state_q == LOCKED) begin
            gnt_s = 3'b000;
        end else if (starved_s) begin
            if (req_s[2]) begin
                gnt_s = 3'b100;
            end else if (req_s[1]) begin
                gnt_s = 3'b010;
            end else begin
                gnt_s = 3'b000;
            end
        end else begin
            if (req_s[1]) begin
                gnt_s = 3'b010;
            end else if (req_s[2]) begin
                gnt_s = 3'b100;
            end else begin
                gnt_s = 3'b000;
            end
        end
    end

    // Memory-side mux; byte enables are suppressed for reads so the memory never sees a stray strobe.
    always_comb begin
        s_en_s    = 1'b0;
        s_we_s    = 1'b0;
        s_addr_s  = '0;
        s_wdata_s = '0;
        s_wstrb_s = '0;
        case (gnt_s)
            3'b001: begin
                s_en_s    = 1'b1;
                s_we_s    = bus.m0_we_i;
                s_addr_s  = bus.m0_addr_i;
                s_wdata_s = bus.m0_wdata_i;
                s_wstrb_s = bus.m0_we_i ? bus.m0_wstrb_i : '0;
            end
            3'b010: begin
                s_en_s    = 1'b1;
                s_we_s    = bus.m1_we_i;
                s_addr_s  = bus.m1_addr_i;
                s_wdata_s = bus.m1_wdata_i;
                s_wstrb_s = bus.m1_we_i ? bus.m1_wstrb_i : '0;
            end
            3'b100: begin
                s_en_s    = 1'b1;
                s_we_s    = bus.m2_we_i;
                s_addr_s  = bus.m2_addr_i;
                s_wdata_s = bus.m2_wdata_i;
                s_wstrb_s = bus.m2_we_i ? bus.m2_wstrb_i : '0;
            end
            default: begin
                s_en_s    = 1'b0;
                s_we_s    = 1'b0;
                s_addr_s  = '0;
                s_wdata_s = '0;
                s_wstrb_s = '0;
            end
        endcase
    end

    // Next owner/valid for the response cycle, and the fetch starvation counter.
    always_comb begin
        valid_d  = |gnt_s;
        owner_d  = owner_q;
        starve_d = starve_q;
        case (gnt_s)
            3'b001:  owner_d = OWN_M0;
            3'b010:  owner_d = OWN_M1;
            3'b100:  owner_d = OWN_M2;
            default: owner_d = owner_q;
        endcase
        if (gnt_s[2]) begin
            starve_d = '0;
        end else if (req_s[2] && !starved_s) begin
            starve_d = starve_q + SW'(1);
        end else begin
            starve_d = starve_q;
        end
    end

    // Response tracking registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q  <= OWN_M0;
            valid_q  <= 1'b0;
            starve_q <= '0;
        end else begin
            owner_q  <= owner_d;
            valid_q  <= valid_d;
            starve_q <= starve_d;
        end
    end

    // Loader lock FSM; an in-flight loader response keeps the bus locked until it is delivered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB;
        end else begin
            case (state_q)
                ARB: begin
                    if (bus.m0_lock_i) begin
                        state_q <= LOCKED;
                    end else begin
                        state_q <= ARB;
                    end
                end
                LOCKED: begin
                    if (!bus.m0_lock_i && !m0_pending_s) begin
                        state_q <= ARB;
                    end else begin
                        state_q <= LOCKED;
                    end
                end
                default: state_q <= ARB;
            endcase
        end
    end

    assign rvalid_s[0] = !rst && valid_q && (owner_q == OWN_M0);
    assign rvalid_s[1] = !rst && valid_q && (owner_q == OWN_M1);
    assign rvalid_s[2] = !rst && valid_q && (owner_q == OWN_M2);

    assign bus.m0_gnt_o    = gnt_s[0];
    assign bus.m1_gnt_o    = gnt_s[1];
    assign bus.m2_gnt_o    = gnt_s[2];
    assign bus.m0_rvalid_o = rvalid_s[0];
    assign bus.m1_rvalid_o = rvalid_s[1];
    assign bus.m2_rvalid_o = rvalid_s[2];
    assign bus.m0_rdata_o  = rvalid_s[0] ? bus.s_rdata_i : '0;
    assign bus.m1_rdata_o  = rvalid_s[1] ? bus.s_rdata_i : '0;
    assign bus.m2_rdata_o  = rvalid_s[2] ? bus.s_rdata_i : '0;

    // Hold reacts to the lock request combinationally so the core stalls in the same cycle.
    assign bus.hold_o    = !rst && ((state_q == LOCKED) || bus.m0_lock_i);
    assign bus.s_en_o    = s_en_s;
    assign bus.s_we_o    = s_we_s;
    assign bus.s_addr_o  = s_addr_s;
    assign bus.s_wdata_o = s_wdata_s;
    assign bus.s_wstrb_o = s_wstrb_s;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: a reference arbiter model plus a response scoreboard,
// and directed sequences for reset, contention, starvation, lock, reset mid-access and byte writes.
module tb_mem_bus_arbiter;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SMAX = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.AW(AW), .DW(DW)) bus ();
    mem_bus_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SMAX)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [2:0]  req;
    logic [2:0]  we;
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [3:0]  wstrb [3];
    logic        lock;

    assign bus.m0_req_i = req[0];  assign bus.m0_we_i = we[0];  assign bus.m0_addr_i = addr[0];
    assign bus.m0_wdata_i = wdata[0];  assign bus.m0_wstrb_i = wstrb[0];  assign bus.m0_lock_i = lock;
    assign bus.m1_req_i = req[1];  assign bus.m1_we_i = we[1];  assign bus.m1_addr_i = addr[1];
    assign bus.m1_wdata_i = wdata[1];  assign bus.m1_wstrb_i = wstrb[1];
    assign bus.m2_req_i = req[2];  assign bus.m2_we_i = we[2];  assign bus.m2_addr_i = addr[2];
    assign bus.m2_wdata_i = wdata[2];  assign bus.m2_wstrb_i = wstrb[2];

    // Memory model: registered read data, byte-strobed writes.
    logic [31:0] mem [1024];
    logic [31:0] s_rdata = 32'h0;
    assign bus.s_rdata_i = s_rdata;
    always @(posedge clk) begin
        if (bus.s_en_o) begin
            if (bus.s_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (bus.s_wstrb_o[b]) mem[bus.s_addr_o[11:2]][8*b +: 8] <= bus.s_wdata_o[8*b +: 8];
            end else begin
                s_rdata <= mem[bus.s_addr_o[11:2]];
            end
        end
    end

    wire [2:0]   gnt_v    = {bus.m2_gnt_o, bus.m1_gnt_o, bus.m0_gnt_o};
    wire [2:0]   rvalid_v = {bus.m2_rvalid_o, bus.m1_rvalid_o, bus.m0_rvalid_o};
    logic [31:0] rdata_v [3];
    assign rdata_v[0] = bus.m0_rdata_o;
    assign rdata_v[1] = bus.m1_rdata_o;
    assign rdata_v[2] = bus.m2_rdata_o;

    typedef struct packed {
        logic [1:0]  m;
        logic        we;
        logic [31:0] data;
    } exp_t;

    exp_t        sb_q [$];
    logic [31:0] ref_mem [1024];
    logic        m_locked;
    logic [2:0]  m_starve;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic chk_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", tag, $time, act, exp);
        end
    endtask

    function automatic logic [2:0] model_gnt();
        if (req[0]) return 3'b001;
        if (m_locked) return 3'b000;
        if (m_starve == 3'(SMAX)) begin
            if (req[2]) return 3'b100;
            if (req[1]) return 3'b010;
        end else begin
            if (req[1]) return 3'b010;
            if (req[2]) return 3'b100;
        end
        return 3'b000;
    endfunction

    // Cycle monitor: checks grants, hold, bus mux and responses against the model every cycle.
    initial begin : monitor
        exp_t       e;
        logic [2:0] eg;
        logic       m0_out;
        int         w;
        m_locked = 1'b0;
        m_starve = 3'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk_val("rst_gnt", gnt_v, 3'b000);
                chk_val("rst_rvalid", rvalid_v, 3'b000);
                chk_val("rst_s_en", bus.s_en_o, 1'b0);
                chk_val("rst_hold", bus.hold_o, 1'b0);
                m_locked = 1'b0;
                m_starve = 3'd0;
                sb_q.delete();
            end else begin
                eg = model_gnt();
                chk_val("gnt", gnt_v, eg);
                chk_val("hold", bus.hold_o, m_locked | lock);
                m0_out = 1'b0;
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    chk_val("rvalid", rvalid_v, 3'b001 << e.m);
                    if (!e.we) chk_val("rdata", rdata_v[e.m], e.data);
                    for (int i = 0; i < 3; i++)
                        if (i != int'(e.m)) chk_val("rdata_other", rdata_v[i], 32'h0);
                    m0_out = (e.m == 2'd0);
                end else begin
                    chk_val("rvalid_idle", rvalid_v, 3'b000);
                    for (int i = 0; i < 3; i++) chk_val("rdata_idle", rdata_v[i], 32'h0);
                end
                if (eg != 3'b000) begin
                    w = eg[0] ? 0 : (eg[1] ? 1 : 2);
                    chk_val("s_en", bus.s_en_o, 1'b1);
                    chk_val("s_we", bus.s_we_o, we[w]);
                    chk_val("s_addr", bus.s_addr_o, addr[w]);
                    chk_val("s_wdata", bus.s_wdata_o, wdata[w]);
                    chk_val("s_wstrb", bus.s_wstrb_o, we[w] ? wstrb[w] : 4'h0);
                    e.m    = 2'(w);
                    e.we   = we[w];
                    e.data = ref_mem[addr[w][11:2]];
                    sb_q.push_back(e);
                    if (we[w])
                        for (int b = 0; b < 4; b++)
                            if (wstrb[w][b]) ref_mem[addr[w][11:2]][8*b +: 8] = wdata[w][8*b +: 8];
                end else begin
                    chk_val("s_en_idle", bus.s_en_o, 1'b0);
                end
                if (eg[2]) m_starve = 3'd0;
                else if (req[2] && m_starve != 3'(SMAX)) m_starve = m_starve + 3'd1;
                if (!m_locked) m_locked = lock;
                else if (!lock && !m0_out) m_locked = 1'b0;
            end
        end
    end

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    logic [19:0] pat;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i]     = 32'hC0DE_0000 | 32'(i);
            ref_mem[i] = 32'hC0DE_0000 | 32'(i);
        end
        mem[64]  = 32'hDEAD_BEEF;  ref_mem[64]  = 32'hDEAD_BEEF;
        mem[128] = 32'h1122_3344;  ref_mem[128] = 32'h1122_3344;
        rst = 1'b1;
        lock = 1'b0;
        req = 3'b111;
        we = 3'b000;
        for (int i = 0; i < 3; i++) begin
            addr[i] = 32'h10 * 32'(i + 1);
            wdata[i] = 32'h0;
            wstrb[i] = 4'h0;
        end

        // Reset with everyone requesting, then release.
        repeat (4) edge_step();
        rst = 1'b0;
        @(negedge clk);
        chk_val("rst_rel_m0", gnt_v, 3'b001);
        edge_step();
        req = 3'b000;

        // Contention M1 vs M2; M2 read carries a strobe that must be masked.
        edge_step();
        req = 3'b110; addr[1] = 32'h100; addr[2] = 32'h0; wstrb[2] = 4'hF;
        @(negedge clk);
        chk_val("cont_m1_gnt", bus.m1_gnt_o, 1'b1);
        edge_step();
        req[1] = 1'b0;
        @(negedge clk);
        chk_val("cont_m1_rvalid", bus.m1_rvalid_o, 1'b1);
        chk_val("cont_m1_rdata", bus.m1_rdata_o, 32'hDEAD_BEEF);
        chk_val("cont_m2_gnt", bus.m2_gnt_o, 1'b1);
        edge_step();
        req = 3'b000; wstrb[2] = 4'h0;

        // Starvation: M2 must win every fifth cycle.
        edge_step();
        req = 3'b110; addr[1] = 32'h40; addr[2] = 32'h80;
        pat = 20'h0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            pat[k] = bus.m2_gnt_o;
            edge_step();
        end
        req = 3'b000;
        @(negedge clk);
        chk_val("starve_pat", pat, 20'h84210);
        chk_val("starve_clr", dut.starve_q, 3'd0);

        // Lock asserted with M1 granted in the same cycle, then loader write.
        edge_step();
        lock = 1'b1; req = 3'b010; addr[1] = 32'h300;
        @(negedge clk);
        chk_val("lock_hold0", bus.hold_o, 1'b1);
        chk_val("lock_m1_gnt0", bus.m1_gnt_o, 1'b1);
        edge_step();
        req = 3'b011; we[0] = 1'b1; addr[0] = 32'h0; wdata[0] = 32'h13; wstrb[0] = 4'hF;
        @(negedge clk);
        chk_val("lock_m1_rvalid", bus.m1_rvalid_o, 1'b1);
        chk_val("lock_m1_blk1", bus.m1_gnt_o, 1'b0);
        chk_val("lock_m0_gnt", bus.m0_gnt_o, 1'b1);
        edge_step();
        req[0] = 1'b0; we[0] = 1'b0;
        @(negedge clk);
        chk_val("lock_m0_ack", bus.m0_rvalid_o, 1'b1);
        chk_val("lock_m1_blk2", bus.m1_gnt_o, 1'b0);
        edge_step();
        lock = 1'b0;
        @(negedge clk);
        chk_val("lock_hold3", bus.hold_o, 1'b1);
        chk_val("lock_m1_blk3", bus.m1_gnt_o, 1'b0);
        edge_step();
        @(negedge clk);
        chk_val("unlock_hold", bus.hold_o, 1'b0);
        chk_val("unlock_m1_gnt", bus.m1_gnt_o, 1'b1);
        edge_step();
        req = 3'b000;
        @(negedge clk);
        chk_val("lock_mem0", mem[0], 32'h0000_0013);

        // Reset while an M2 response is pending.
        edge_step();
        req = 3'b100; addr[2] = 32'h44;
        @(negedge clk);
        chk_val("rma_m2_gnt", bus.m2_gnt_o, 1'b1);
        edge_step();
        req = 3'b000; rst = 1'b1;
        @(negedge clk);
        chk_val("rma_no_rvalid", bus.m2_rvalid_o, 1'b0);
        edge_step();
        edge_step();
        rst = 1'b0; req = 3'b110; addr[1] = 32'h48; addr[2] = 32'h4C;
        @(negedge clk);
        chk_val("rma_m1_gnt", bus.m1_gnt_o, 1'b1);
        chk_val("rma_rvalid0", rvalid_v, 3'b000);
        edge_step();
        req[1] = 1'b0;
        @(negedge clk);
        chk_val("rma_m1_rvalid", bus.m1_rvalid_o, 1'b1);
        chk_val("rma_m2_gnt2", bus.m2_gnt_o, 1'b1);
        edge_step();
        req = 3'b000;

        // Single-byte write, then read it back through M2.
        edge_step();
        req = 3'b010; we[1] = 1'b1; addr[1] = 32'h200; wdata[1] = 32'h00AB_0000; wstrb[1] = 4'h4;
        @(negedge clk);
        chk_val("bw_s_wstrb", bus.s_wstrb_o, 4'h4);
        edge_step();
        req = 3'b000; we[1] = 1'b0;
        @(negedge clk);
        chk_val("bw_m1_ack", bus.m1_rvalid_o, 1'b1);
        chk_val("bw_mem", mem[128], 32'h11AB_3344);
        edge_step();
        req = 3'b100; addr[2] = 32'h200;
        edge_step();
        req = 3'b000;
        @(negedge clk);
        chk_val("bw_readback", bus.m2_rdata_o, 32'h11AB_3344);
        repeat (2) edge_step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
